// File: rtl/e_q_clk_gen_pkg.sv
// Shared encodings for the 6809 E/Q bus-clock generator.
// Phase codes, FSM state type and counter-width helper.
package eq_clk_pkg;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int cnt_width(input int q);
    return (q < 2) ? 1 : $clog2(q);
  endfunction

endpackage

// File: rtl/e_q_clk_gen_if.sv
// Control and clock-output bundle of the E/Q generator.
// master = the clock generator, slave = the bus-side user.
interface e_q_clk_gen_if;

  logic       i_run;
  logic       i_mrdy_n;
  logic       o_e_clk;
  logic       o_q_clk;
  logic       o_e_rise;
  logic       o_e_fall;
  logic       o_cycle_start;
  logic       o_stretching;
  logic [1:0] o_phase;

  modport master (
    input  i_run, i_mrdy_n,
    output o_e_clk, o_q_clk, o_e_rise, o_e_fall,
    output o_cycle_start, o_stretching, o_phase
  );

  modport slave (
    output i_run, i_mrdy_n,
    input  o_e_clk, o_q_clk, o_e_rise, o_e_fall,
    input  o_cycle_start, o_stretching, o_phase
  );

endinterface

// File: rtl/e_q_clk_gen_mrdy_sync.sv
// Two-flop MRDY synchronizer, resets to the idle (high) level.
// Only compiled when EQ_MRDY_SYNC_EN is defined.
`ifdef EQ_MRDY_SYNC_EN
module mrdy_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s0;

  // Double-register the asynchronous ready input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end

endmodule
`endif

// File: rtl/e_q_clk_gen.sv
// 6809 E/Q quadrature clock master with MRDY stretch and clean stop.
// EQ_MRDY_SYNC_EN: pass i_mrdy_n through a 2-flop synchronizer.
module e_q_clk_gen
  import eq_clk_pkg::*;
#(
  parameter int QUARTER     = 25,
  parameter int MAX_STRETCH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  e_q_clk_gen_if.master bus
);

  localparam int CW = cnt_width(QUARTER);
  localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);
  localparam logic [3:0] MAX_S = 4'(MAX_STRETCH);

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] phase, phase_n;
  logic [3:0] scnt, scnt_n;
  logic str, str_n;
  logic rise, rise_n;
  logic fall, fall_n;
  logic start, start_n;
  logic e_r, q_r;
  logic mrdy_n;
  logic stretch_ok;

`ifdef EQ_MRDY_SYNC_EN
  mrdy_sync u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (bus.i_mrdy_n),
    .q   (mrdy_n)
  );
`else
  assign mrdy_n = bus.i_mrdy_n;
`endif

  assign stretch_ok = (phase == PH3) && (cnt == LAST)
                   && !mrdy_n && (scnt < MAX_S);

  // Register state and outputs decoded from next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      phase <= PH0;
      scnt  <= '0;
      str   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      start <= 1'b0;
      e_r   <= 1'b0;
      q_r   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      phase <= phase_n;
      scnt  <= scnt_n;
      str   <= str_n;
      rise  <= rise_n;
      fall  <= fall_n;
      start <= start_n;
      e_r   <= (phase_n == PH2) || (phase_n == PH3);
      q_r   <= (phase_n == PH1) || (phase_n == PH2);
    end
  end

  // Quarter counter, phase sequencing, stretch and stop decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phase_n = phase;
    scnt_n  = scnt;
    str_n   = str;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    start_n = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n   = '0;
        phase_n = PH0;
        scnt_n  = '0;
        str_n   = 1'b0;
        if (bus.i_run) begin
          state_n = RUN;
          start_n = 1'b1;
        end
      end
      RUN: begin
        if (cnt != LAST) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n = '0;
          unique case (phase)
            PH0: phase_n = PH1;
            PH1: begin
              phase_n = PH2;
              rise_n  = 1'b1;
            end
            PH2: phase_n = PH3;
            PH3: begin
              if (stretch_ok) begin
                scnt_n = scnt + 4'd1;
                str_n  = 1'b1;
              end else begin
                phase_n = PH0;
                scnt_n  = '0;
                str_n   = 1'b0;
                fall_n  = 1'b1;
                if (bus.i_run) start_n = 1'b1;
                else state_n = IDLE;
              end
            end
          endcase
        end
      end
    endcase
  end

  assign bus.o_e_clk       = e_r;
  assign bus.o_q_clk       = q_r;
  assign bus.o_e_rise      = rise;
  assign bus.o_e_fall      = fall;
  assign bus.o_cycle_start = start;
  assign bus.o_stretching  = str;
  assign bus.o_phase       = phase;

endmodule

// File: tb/tb_e_q_clk_gen.sv
// Scoreboard bench for e_q_clk_gen: expected edge/strobe events
// are queued as stimulus is driven and matched as they appear.
module tb_e_q_clk_gen;
  import eq_clk_pkg::*;

  localparam int Q  = 4;
  localparam int MS = 2;

  localparam int K_QR = 0;
  localparam int K_QF = 1;
  localparam int K_ER = 2;
  localparam int K_EL = 3;
  localparam int K_EF = 4;
  localparam int K_FL = 5;
  localparam int K_SN = 6;
  localparam int K_SF = 7;
  localparam int K_ST = 8;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  ev_t exp_q[$];
  logic [8:0] hit;
  logic e_p = 1'b0;
  logic q_p = 1'b0;
  logic s_p = 1'b0;

  e_q_clk_gen_if bus();

  e_q_clk_gen #(
    .QUARTER     (Q),
    .MAX_STRETCH (MS)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input int k, input int c);
    ev_t x;
    x.kind = k;
    x.cyc  = c;
    exp_q.push_back(x);
  endtask

  task automatic observe(input int k);
    ev_t x;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", k * 100000 + cyc, -1);
      return;
    end
    x = exp_q.pop_front();
    chk("event", k * 100000 + cyc, x.kind * 100000 + x.cyc);
    case (k)
      K_QR: chk("phase_at_q_rise", int'(bus.o_phase), int'(PH1));
      K_ER: chk("phase_at_e_rise", int'(bus.o_phase), int'(PH2));
      K_QF: chk("phase_at_q_fall", int'(bus.o_phase), int'(PH3));
      K_ST: chk("phase_at_start", int'(bus.o_phase), int'(PH0));
      default: ;
    endcase
  endtask

  // Edge/strobe monitor; sampled on the inactive edge.
  always @(negedge clk) begin
    if (mon_en) begin
      hit[K_QR] = bus.o_q_clk && !q_p;
      hit[K_QF] = !bus.o_q_clk && q_p;
      hit[K_ER] = bus.o_e_rise;
      hit[K_EL] = bus.o_e_clk && !e_p;
      hit[K_EF] = bus.o_e_fall;
      hit[K_FL] = !bus.o_e_clk && e_p;
      hit[K_SN] = bus.o_stretching && !s_p;
      hit[K_SF] = !bus.o_stretching && s_p;
      hit[K_ST] = bus.o_cycle_start;
      for (int k = 0; k < 9; k++) if (hit[k]) observe(k);
    end
    e_p = bus.o_e_clk;
    q_p = bus.o_q_clk;
    s_p = bus.o_stretching;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One bus cycle from its start cycle t; req = MRDY stretch
  // quarters requested, lead = cycles MRDY precedes the first
  // decision cycle, s = stretches expected, more = keep running.
  task automatic bus_cycle(input int t, input int req, input int lead,
                           input int s, input bit more,
                           output int e);
    int d0;
    int rel;
    e  = t + 4 * Q + s * Q;
    d0 = t + 4 * Q - 1;
    push(K_QR, t + Q);
    push(K_ER, t + 2 * Q);
    push(K_EL, t + 2 * Q);
    push(K_QF, t + 3 * Q);
    if (s > 0) push(K_SN, t + 4 * Q);
    push(K_EF, e);
    push(K_FL, e);
    if (s > 0) push(K_SF, e);
    if (more) push(K_ST, e);
    if (!more) begin
      wait_cyc(t + Q + 1);
      bus.i_run = 1'b0;
    end
    if (req > 0) begin
      rel = d0 + (req - 1) * Q + 1;
      if (rel > e) rel = e;
      wait_cyc(d0 - lead);
      bus.i_mrdy_n = 1'b0;
      wait_cyc(rel);
      bus.i_mrdy_n = 1'b1;
    end
    wait_cyc(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int e;
    int r;
    bus.i_run    = 1'b0;
    bus.i_mrdy_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_e", int'(bus.o_e_clk), 0);
    chk("rst_q", int'(bus.o_q_clk), 0);
    chk("rst_phase", int'(bus.o_phase), int'(PH0));
    chk("rst_rise", int'(bus.o_e_rise), 0);
    chk("rst_fall", int'(bus.o_e_fall), 0);
    chk("rst_start", int'(bus.o_cycle_start), 0);
    chk("rst_stretch", int'(bus.o_stretching), 0);

    t = cyc + 1;
    push(K_ST, t);
    mon_en  = 1'b1;
    rst     = 1'b0;
    bus.i_run = 1'b1;

    bus_cycle(t, 0, 3, 0, 1'b1, e);
    t = e;
    bus_cycle(t, 2, 3, 2, 1'b1, e);
    t = e;
    bus_cycle(t, 5, 3, MS, 1'b1, e);
    t = e;
    bus_cycle(t, 1, 3, 1, 1'b0, e);

    repeat (4) begin
      @(negedge clk);
      chk("idle_e", int'(bus.o_e_clk), 0);
      chk("idle_q", int'(bus.o_q_clk), 0);
      chk("idle_phase", int'(bus.o_phase), int'(PH0));
    end

    t = cyc + 1;
    push(K_ST, t);
    bus.i_run = 1'b1;
    bus_cycle(t, 1, 3, 1, 1'b1, e);
    t = e;

`ifdef EQ_MRDY_SYNC_EN
    bus_cycle(t, 1, 1, 0, 1'b1, e);
    t = e;
    bus_cycle(t, 1, 3, 1, 1'b1, e);
    t = e;
`endif

    push(K_QR, t + Q);
    push(K_ER, t + 2 * Q);
    push(K_EL, t + 2 * Q);
    push(K_QF, t + 3 * Q);
    push(K_SN, t + 4 * Q);
    r = t + 4 * Q + 2;
    push(K_FL, r + 1);
    push(K_SF, r + 1);
    wait_cyc(t + 3 * Q);
    bus.i_mrdy_n = 1'b0;
    wait_cyc(r);
    chk("pre_rst_stretch", int'(bus.o_stretching), 1);
    rst          = 1'b1;
    bus.i_run    = 1'b0;
    bus.i_mrdy_n = 1'b1;
    @(negedge clk);
    chk("midrst_e", int'(bus.o_e_clk), 0);
    chk("midrst_q", int'(bus.o_q_clk), 0);
    chk("midrst_stretch", int'(bus.o_stretching), 0);
    chk("midrst_phase", int'(bus.o_phase), int'(PH0));
    chk("midrst_fall", int'(bus.o_e_fall), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_e", int'(bus.o_e_clk), 0);
    chk("post_rst_start", int'(bus.o_cycle_start), 0);

    t = cyc + 1;
    push(K_ST, t);
    bus.i_run = 1'b1;
    bus_cycle(t, 0, 3, 0, 1'b0, e);
    repeat (8) @(negedge clk);

    chk("events_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/e_q_clk_gen.md
Name: e_q_clk_gen

Overview:
- Generates the 6809 E and Q quadrature bus clocks from the fast PLL clock. This makes the FPGA the bus-clock master, instead of a follower of an external E.
- Supports MRDY-style stretching of E-high in whole quarter-periods.
- Supports stopping cleanly at a cycle boundary.
- Emits single-cycle edge strobes so downstream buffer-enable and delay logic can be phase-aligned without edge detection.

Parameters:
- QUARTER, 25, i_clk cycles per E/Q quarter-phase (100 MHz → 1 MHz E); legal range ≥ 2.
- MAX_STRETCH, 8, maximum extra quarter-phases E may be held high per bus cycle; legal range 0..15.

Ports:
- i_clk  in  1  fast PLL clock; all logic is on its rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_run  in  1  1 = free-run bus cycles; 0 = stop at the next cycle boundary.
- i_mrdy_n  in  1  memory-ready, active-low; 0 requests E-high stretch.
- o_e_clk  out  1  6809 E clock, registered.
- o_q_clk  out  1  6809 Q clock, registered; leads E by one quarter.
- o_e_rise  out  1  1-cycle pulse in the cycle E first reads 1.
- o_e_fall  out  1  1-cycle pulse in the cycle E first reads 0.
- o_cycle_start  out  1  1-cycle pulse on entry to PH0 of a running cycle.
- o_stretching  out  1  high during every stretched quarter.
- o_phase  out  2  current phase encoding (PH0..PH3).

Behaviour:
- State:
  - quarter counter cnt, width clog2(QUARTER), range 0..QUARTER-1;
  - 2-bit phase;
  - 4-bit stretch count scnt;
  - state machine IDLE/RUN.
- Phases (E,Q): PH0=(0,0), PH1=(0,1), PH2=(1,1), PH3=(1,0). All outputs are registered and decoded from the next-state, so E and Q never glitch.
- Reset values:
  - o_e_clk=0, o_q_clk=0, o_phase=PH0;
  - all pulses 0, o_stretching=0;
  - cnt=0, scnt=0, state=IDLE.
- Reset has priority over everything. Reset asserted mid-cycle forces the reset values on the next edge, regardless of phase or stretch.
- IDLE:
  - outputs are held at PH0 values;
  - when i_run=1, go to RUN, cnt=0, phase=PH0, and assert o_cycle_start in that same cycle.
- RUN, advance rule:
  - cnt increments each cycle;
  - at cnt==QUARTER-1, cnt wraps to 0 and phase advances PH0→PH1→PH2→PH3→PH0.
- Stretch:
  - Applies at PH3 with cnt==QUARTER-1 and i_mrdy_n=0 (sampled that cycle) and scnt<MAX_STRETCH.
  - Phase stays PH3, cnt=0, scnt increments, and o_stretching=1 for the whole following quarter.
  - When scnt reaches MAX_STRETCH, the cycle ends normally even if i_mrdy_n=0.
  - scnt clears at PH0 entry.
  - MAX_STRETCH=0 disables stretching.
- Cycle boundary (PH3→PH0):
  - If i_run=1: enter PH0, pulse o_cycle_start.
  - If i_run=0: go to IDLE; o_cycle_start is not pulsed.
  - Deasserting i_run mid-cycle never truncates the current cycle.
- Strobes:
  - o_e_rise asserts in the first cycle of PH2; o_e_fall in the first cycle of PH0 after PH3 (including the entry to IDLE).
  - A stretched PH3→PH3 transition produces no strobes.
- Nominal period: 4·QUARTER cycles plus QUARTER per stretch. E duty is 50% when unstretched.

Optional Feature:
- Macro: EQ_MRDY_SYNC_EN.
- Defined: i_mrdy_n passes through a 2-flop synchronizer (reset value 1). Stretch decisions use the synchronized value, adding 2 cycles of input latency; MRDY must be asserted at least 2 i_clk before the PH3 decision cycle.
- Undefined: i_mrdy_n is used directly (caller guarantees it is synchronous to i_clk).

Decomposition:
- Package eq_clk_pkg holds:
  - phase encodings PH0..PH3 as 2-bit localparams;
  - the IDLE/RUN state encoding;
  - a helper function for the counter width.
- One sub-module, mrdy_sync (2-flop synchronizer, synchronous active-high reset to 1), instantiated only under EQ_MRDY_SYNC_EN.

Test Plan:
- QUARTER=4, i_run=1 from reset release, i_mrdy_n=1 → E period 16 cycles; Q rises 4 cycles after o_cycle_start, E rises 8 cycles after, Q falls 12, E falls 16. o_e_rise and o_e_fall are single-cycle pulses.
- QUARTER=4, i_mrdy_n=0 held through PH3 for 2 decision points, MAX_STRETCH=8 → E high for 16 cycles instead of 8, o_stretching high 8 cycles, period 24.
- QUARTER=4, MAX_STRETCH=2, i_mrdy_n stuck 0 → exactly 2 stretch quarters, then E falls; the next cycle starts with scnt=0.
- i_run dropped during PH1 → cycle completes (E falls at cycle end), no o_cycle_start follows, outputs hold at 0. Re-raising i_run restarts with o_cycle_start in the same cycle as entry to RUN.
- i_rst pulsed during a stretched PH3 → next edge E=0, Q=0, o_stretching=0, phase PH0, IDLE.
- With EQ_MRDY_SYNC_EN, i_mrdy_n asserted only 1 cycle before the decision cycle → no stretch; asserted 3 cycles before → stretch.
